// File: rtl/secuenciador_serpiente.sv
// ============================================================================
//  Module   : secuenciador_serpiente
//  Purpose  : Per-tick snake body update. Computes the new head, checks walls
//             and food, shifts the body RAM one slot toward the tail while
//             checking for self-collision, then writes the new head.
//  Option   : SERPIENTE_PAREDES_CICLICAS_EN -> board edges wrap around
//             instead of ending the game.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module secuenciador_serpiente #(
    parameter int ANCHO    = 40,
    parameter int ALTO     = 30,
    parameter int LONG_MAX = 64,
    parameter int LONG_INI = 3,
    parameter int X_INI    = 10,
    parameter int Y_INI    = 15
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        paso_i,
    input  logic [2:0]                  accion_i,
    input  logic [5:0]                  comida_x_i,
    input  logic [5:0]                  comida_y_i,
    input  logic [11:0]                 mem_rdata_i,
    output logic [$clog2(LONG_MAX)-1:0] mem_dir_o,
    output logic                        mem_we_o,
    output logic [11:0]                 mem_wdata_o,
    output logic [5:0]                  cabeza_x_o,
    output logic [5:0]                  cabeza_y_o,
    output logic [6:0]                  longitud_o,
    output logic                        comida_nueva_o,
    output logic                        fin_juego_o,
    output logic                        ocupado_o
);

    localparam int AW = $clog2(LONG_MAX);

    localparam logic [2:0] S_INIT     = 3'd0;
    localparam logic [2:0] S_REPOSO   = 3'd1;
    localparam logic [2:0] S_CALC     = 3'd2;
    localparam logic [2:0] S_LEER     = 3'd3;
    localparam logic [2:0] S_ESCRIBIR = 3'd4;
    localparam logic [2:0] S_CABEZA   = 3'd5;
    localparam logic [2:0] S_FIN      = 3'd6;

    localparam logic [5:0]    C_ANCHO_M1 = 6'(ANCHO - 1);
    localparam logic [5:0]    C_ALTO_M1  = 6'(ALTO - 1);
    localparam logic [6:0]    C_LONG_MAX = 7'(LONG_MAX);
    localparam logic [AW-1:0] C_UNO      = AW'(1);
    localparam logic [AW-1:0] C_INI_ULT  = AW'(LONG_INI - 1);

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [2:0]    accion_q, accion_d;
    logic [5:0]    hx_q, hx_d, hy_q, hy_d;
    logic          comer_q, comer_d;
    logic [5:0]    cabeza_x_q, cabeza_x_d, cabeza_y_q, cabeza_y_d;
    logic [6:0]    longitud_q, longitud_d;
    logic          fin_q, fin_d;

    logic [5:0]    nx_w, ny_w;
    logic          borde_w, pared_w;
    logic          mem_we_w, falla_w;
    logic [AW-1:0] mem_dir_w;
    logic [11:0]   mem_wdata_w;

    // Candidate head one step along the latched direction; borde_w flags an edge crossing
    always_comb begin
        nx_w    = cabeza_x_q;
        ny_w    = cabeza_y_q;
        borde_w = 1'b0;
        case (accion_q)
            3'd1: begin
                borde_w = (cabeza_y_q == 6'd0);
                ny_w    = borde_w ? C_ALTO_M1 : cabeza_y_q - 6'd1;
            end
            3'd2: begin
                borde_w = (cabeza_y_q == C_ALTO_M1);
                ny_w    = borde_w ? 6'd0 : cabeza_y_q + 6'd1;
            end
            3'd3: begin
                borde_w = (cabeza_x_q == 6'd0);
                nx_w    = borde_w ? C_ANCHO_M1 : cabeza_x_q - 6'd1;
            end
            3'd4: begin
                borde_w = (cabeza_x_q == C_ANCHO_M1);
                nx_w    = borde_w ? 6'd0 : cabeza_x_q + 6'd1;
            end
            default: ;
        endcase
    end

`ifdef SERPIENTE_PAREDES_CICLICAS_EN
    assign pared_w = 1'b0;
`else
    assign pared_w = borde_w;
`endif

    // Sequencer next-state logic and RAM port drive
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        accion_d    = accion_q;
        hx_d        = hx_q;
        hy_d        = hy_q;
        comer_d     = comer_q;
        cabeza_x_d  = cabeza_x_q;
        cabeza_y_d  = cabeza_y_q;
        longitud_d  = longitud_q;
        fin_d       = fin_q;
        mem_we_w    = 1'b0;
        mem_dir_w   = '0;
        mem_wdata_w = '0;
        falla_w     = 1'b0;
        case (state_q)
            S_INIT: begin
                mem_we_w    = 1'b1;
                mem_dir_w   = idx_q;
                mem_wdata_w = {6'(Y_INI), 6'(X_INI) - 6'(idx_q)};
                if (idx_q == C_INI_ULT) begin
                    idx_d   = '0;
                    state_d = S_REPOSO;
                end else begin
                    idx_d = idx_q + C_UNO;
                end
            end
            S_REPOSO: begin
                if (paso_i && (accion_i >= 3'd1) && (accion_i <= 3'd4) && !fin_q) begin
                    accion_d = accion_i;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (pared_w) begin
                    falla_w = 1'b1;
                    fin_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    hx_d    = nx_w;
                    hy_d    = ny_w;
                    comer_d = ({ny_w, nx_w} == {comida_y_i, comida_x_i});
                    // Growing keeps the old tail, so the shift starts one slot further out
                    if (comer_d && (longitud_q < C_LONG_MAX))
                        idx_d = AW'(longitud_q);
                    else
                        idx_d = AW'(longitud_q - 7'd1);
                    state_d = S_LEER;
                end
            end
            S_LEER: begin
                mem_dir_w = idx_q - C_UNO;
                state_d   = S_ESCRIBIR;
            end
            S_ESCRIBIR: begin
                mem_dir_w   = idx_q;
                mem_wdata_w = mem_rdata_i;
                if (mem_rdata_i == {hy_q, hx_q}) begin
                    falla_w = 1'b1;
                    fin_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    mem_we_w = 1'b1;
                    idx_d    = idx_q - C_UNO;
                    state_d  = (idx_q != C_UNO) ? S_LEER : S_CABEZA;
                end
            end
            S_CABEZA: begin
                mem_we_w    = 1'b1;
                mem_wdata_w = {hy_q, hx_q};
                cabeza_x_d  = hx_q;
                cabeza_y_d  = hy_q;
                if (comer_q && (longitud_q < C_LONG_MAX))
                    longitud_d = longitud_q + 7'd1;
                state_d = S_REPOSO;
            end
            S_FIN: ;
            default: begin
                idx_d   = '0;
                state_d = S_INIT;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_INIT;
            idx_q      <= '0;
            accion_q   <= 3'd0;
            hx_q       <= 6'd0;
            hy_q       <= 6'd0;
            comer_q    <= 1'b0;
            cabeza_x_q <= 6'(X_INI);
            cabeza_y_q <= 6'(Y_INI);
            longitud_q <= 7'(LONG_INI);
            fin_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            accion_q   <= accion_d;
            hx_q       <= hx_d;
            hy_q       <= hy_d;
            comer_q    <= comer_d;
            cabeza_x_q <= cabeza_x_d;
            cabeza_y_q <= cabeza_y_d;
            longitud_q <= longitud_d;
            fin_q      <= fin_d;
        end
    end

    // RAM port reads idle while reset is held, even though INIT is already selected
    assign mem_we_o       = mem_we_w & rst_ni;
    assign mem_dir_o      = rst_ni ? mem_dir_w : '0;
    assign mem_wdata_o    = rst_ni ? mem_wdata_w : 12'd0;
    assign cabeza_x_o     = cabeza_x_q;
    assign cabeza_y_o     = cabeza_y_q;
    assign longitud_o     = longitud_q;
    assign comida_nueva_o = (state_q == S_CABEZA) && comer_q;
    assign fin_juego_o    = fin_q | falla_w;
    assign ocupado_o      = (state_q != S_REPOSO) && (state_q != S_FIN);

endmodule

`default_nettype wire

// File: tb/tb_secuenciador_serpiente.sv
// ============================================================================
//  Module   : tb_secuenciador_serpiente
//  Purpose  : Self-checking bench for secuenciador_serpiente with a
//             one-cycle-latency body RAM model and hand-computed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_secuenciador_serpiente;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        paso;
    logic [2:0]  accion;
    logic [5:0]  comida_x, comida_y;
    logic [11:0] mem_rdata;
    logic [5:0]  mem_dir;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [5:0]  cabeza_x, cabeza_y;
    logic [6:0]  longitud;
    logic        comida_nueva, fin_juego, ocupado;

    logic [11:0] ram [64];
    int          n_wr = 0;
    int          n_ok = 0;
    int          n_total = 0;

    typedef struct {
        logic [2:0] accion;
        logic [5:0] fx, fy;
        int         e_x, e_y, e_long, e_com, e_ocup, e_wr, e_fin, e_fin_ciclo;
    } vec_t;
    vec_t tabla [15];

    secuenciador_serpiente dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .paso_i         (paso),
        .accion_i       (accion),
        .comida_x_i     (comida_x),
        .comida_y_i     (comida_y),
        .mem_rdata_i    (mem_rdata),
        .mem_dir_o      (mem_dir),
        .mem_we_o       (mem_we),
        .mem_wdata_o    (mem_wdata),
        .cabeza_x_o     (cabeza_x),
        .cabeza_y_o     (cabeza_y),
        .longitud_o     (longitud),
        .comida_nueva_o (comida_nueva),
        .fin_juego_o    (fin_juego),
        .ocupado_o      (ocupado)
    );

    always #5 clk = ~clk;

    // Body RAM: registered write, one-cycle read latency
    always @(posedge clk) begin
        if (mem_we) ram[mem_dir] <= mem_wdata;
        mem_rdata <= ram[mem_dir];
    end

    always @(posedge clk) if (mem_we) n_wr <= n_wr + 1;

    function automatic int yx(input int y, input int x);
        return (y << 6) | x;
    endfunction

    task automatic comparar(input string nombre, input int actual, input int esperado);
        n_total++;
        if (actual == esperado) n_ok++;
        else $display("FAIL %s: got %0d, expected %0d", nombre, actual, esperado);
    endtask

    task automatic comparar_ram(input int dir, input int y, input int x, input string tag);
        comparar($sformatf("%s ram[%0d]", tag, dir), int'(ram[dir]), yx(y, x));
    endtask

    // Release reset and check that INIT lays down the initial body
    task automatic soltar_reset(input string tag);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        comparar({tag, " ocupado during init"}, int'(ocupado), 1);
        @(posedge clk); #1;
        comparar({tag, " ocupado after init"}, int'(ocupado), 0);
        comparar({tag, " longitud"}, int'(longitud), 3);
        comparar_ram(0, 15, 10, tag);
        comparar_ram(1, 15, 9, tag);
        comparar_ram(2, 15, 8, tag);
    endtask

    // One game tick; measures busy cycles, food pulses, writes and fault cycle
    task automatic tick(input logic [2:0] a, input logic [5:0] fx, input logic [5:0] fy,
                        input bit extra, output int ocup, output int com,
                        output int wr, output int fin_ciclo);
        int wr0;
        @(posedge clk); #1;
        accion = a; comida_x = fx; comida_y = fy; paso = 1'b1;
        wr0 = n_wr;
        @(posedge clk); #1;
        paso = 1'b0;
        ocup = 0; com = 0; fin_ciclo = 0;
        for (int c = 0; c < 300; c++) begin
            if (!ocupado) break;
            ocup++;
            if (comida_nueva) com++;
            if (fin_juego && fin_ciclo == 0) fin_ciclo = ocup;
            paso = extra && (c == 1);
            @(posedge clk); #1;
        end
        paso = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        wr = n_wr - wr0;
    endtask

    task automatic aplicar(input int i);
        int ocup, com, wr, fc;
        tick(tabla[i].accion, tabla[i].fx, tabla[i].fy, 1'b0, ocup, com, wr, fc);
        comparar($sformatf("v%0d cabeza_x", i), int'(cabeza_x), tabla[i].e_x);
        comparar($sformatf("v%0d cabeza_y", i), int'(cabeza_y), tabla[i].e_y);
        comparar($sformatf("v%0d longitud", i), int'(longitud), tabla[i].e_long);
        comparar($sformatf("v%0d comida pulses", i), com, tabla[i].e_com);
        comparar($sformatf("v%0d ocupado cycles", i), ocup, tabla[i].e_ocup);
        comparar($sformatf("v%0d ram writes", i), wr, tabla[i].e_wr);
        comparar($sformatf("v%0d fin_juego", i), int'(fin_juego), tabla[i].e_fin);
        comparar($sformatf("v%0d fin cycle", i), fc, tabla[i].e_fin_ciclo);
    endtask

    initial begin
        int ocup, com, wr, fc;
        // accion, food x/y, head x/y, length, food pulses, busy cycles, writes, fin, fin cycle
        tabla[0]  = '{3'd4, 6'd11, 6'd15, 11, 15, 4, 1,  8, 4, 0, 0};
        tabla[1]  = '{3'd4, 6'd0,  6'd0,  12, 15, 4, 0,  8, 4, 0, 0};
        tabla[2]  = '{3'd0, 6'd0,  6'd0,  12, 15, 4, 0,  0, 0, 0, 0};
        tabla[3]  = '{3'd7, 6'd0,  6'd0,  12, 15, 4, 0,  0, 0, 0, 0};
        tabla[4]  = '{3'd4, 6'd13, 6'd15, 13, 15, 5, 1, 10, 5, 0, 0};
        tabla[5]  = '{3'd4, 6'd0,  6'd0,  14, 15, 5, 0, 10, 5, 0, 0};
        tabla[6]  = '{3'd2, 6'd0,  6'd0,  14, 16, 5, 0, 10, 5, 0, 0};
        tabla[7]  = '{3'd3, 6'd0,  6'd0,  13, 16, 5, 0, 10, 5, 0, 0};
        tabla[8]  = '{3'd1, 6'd0,  6'd0,  13, 16, 5, 0,  3, 0, 1, 3};
        tabla[9]  = '{3'd4, 6'd0,  6'd0,  13, 16, 5, 0,  0, 0, 1, 0};
        tabla[10] = '{3'd4, 6'd11, 6'd15, 11, 15, 4, 1,  8, 4, 0, 0};
        tabla[11] = '{3'd4, 6'd0,  6'd0,  12, 15, 4, 0,  8, 4, 0, 0};
        tabla[12] = '{3'd2, 6'd0,  6'd0,  12, 16, 4, 0,  8, 4, 0, 0};
        tabla[13] = '{3'd3, 6'd0,  6'd0,  11, 16, 4, 0,  8, 4, 0, 0};
        tabla[14] = '{3'd1, 6'd0,  6'd0,  11, 15, 4, 0,  8, 4, 0, 0};

        rst_n = 1'b0; paso = 1'b0; accion = 3'd0; comida_x = 6'd0; comida_y = 6'd0;

        // Reset values while reset is held
        repeat (2) @(posedge clk);
        #1;
        comparar("rst mem_we", int'(mem_we), 0);
        comparar("rst mem_dir", int'(mem_dir), 0);
        comparar("rst mem_wdata", int'(mem_wdata), 0);
        comparar("rst cabeza_x", int'(cabeza_x), 10);
        comparar("rst cabeza_y", int'(cabeza_y), 15);
        comparar("rst longitud", int'(longitud), 3);
        comparar("rst comida_nueva", int'(comida_nueva), 0);
        comparar("rst fin_juego", int'(fin_juego), 0);
        comparar("rst ocupado", int'(ocupado), 1);
        soltar_reset("init");

        // Length-5 run ending in self-collision, then an ignored tick
        for (int i = 0; i <= 9; i++) begin
            aplicar(i);
            if (i == 0) begin
                comparar_ram(0, 15, 11, "eat");
                comparar_ram(1, 15, 10, "eat");
                comparar_ram(2, 15, 9, "eat");
                comparar_ram(3, 15, 8, "eat");
            end
        end

        // Fresh start; same square with length 4 is legal (tail cell)
        rst_n = 1'b0;
        soltar_reset("reinit");
        for (int i = 10; i <= 14; i++) aplicar(i);

        // Reset in the middle of a shift
        @(posedge clk); #1;
        accion = 3'd4; comida_x = 6'd0; comida_y = 6'd0; paso = 1'b1;
        @(posedge clk); #1;
        paso = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        comparar_ram(2, 16, 11, "midshift before reset");
        rst_n = 1'b0;
        #1;
        comparar("midshift ocupado", int'(ocupado), 1);
        comparar("midshift mem_we", int'(mem_we), 0);
        comparar("midshift longitud", int'(longitud), 3);
        comparar("midshift cabeza_x", int'(cabeza_x), 10);
        comparar("midshift cabeza_y", int'(cabeza_y), 15);
        soltar_reset("midshift");

        // Plain move with a second tick dropped while busy
        tick(3'd4, 6'd0, 6'd0, 1'b1, ocup, com, wr, fc);
        comparar("move cabeza_x", int'(cabeza_x), 11);
        comparar("move ocupado cycles", ocup, 6);
        comparar("move ram writes", wr, 3);
        comparar("move comida pulses", com, 0);
        comparar("move longitud", int'(longitud), 3);
        comparar_ram(0, 15, 11, "move");
        comparar_ram(1, 15, 10, "move");
        comparar_ram(2, 15, 9, "move");

        // Run right up to the last column, then into the wall
        for (int k = 0; k < 28; k++) tick(3'd4, 6'd0, 6'd0, 1'b0, ocup, com, wr, fc);
        comparar("edge cabeza_x", int'(cabeza_x), 39);
        comparar("edge fin_juego", int'(fin_juego), 0);
        tick(3'd4, 6'd0, 6'd0, 1'b0, ocup, com, wr, fc);
`ifdef SERPIENTE_PAREDES_CICLICAS_EN
        comparar("wall cabeza_x", int'(cabeza_x), 0);
        comparar("wall fin_juego", int'(fin_juego), 0);
        comparar("wall ocupado cycles", ocup, 6);
        comparar("wall ram writes", wr, 3);
        comparar("wall fin cycle", fc, 0);
`else
        comparar("wall cabeza_x", int'(cabeza_x), 39);
        comparar("wall fin_juego", int'(fin_juego), 1);
        comparar("wall ocupado cycles", ocup, 1);
        comparar("wall ram writes", wr, 0);
        comparar("wall fin cycle", fc, 1);
        tick(3'd3, 6'd0, 6'd0, 1'b0, ocup, com, wr, fc);
        comparar("after wall ocupado cycles", ocup, 0);
        comparar("after wall ram writes", wr, 0);
        comparar("after wall cabeza_x", int'(cabeza_x), 39);
`endif

        $display("%0d/%0d checks passed", n_ok, n_total);
        $finish;
    end

endmodule

`default_nettype wire
